// File: rtl/qpsk_phase_receiver.sv
// Buffers 4-bit QPSK phase indices, serializes them MSB first and checks the bits against PRBS7.
// First serial bit one cycle after a write; phase_ready is low only while the buffer is full.

module sym_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_dat = mem[rd_ptr[AW-1:0]];
endmodule

module qpsk_phase_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int WINDOW     = 64,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       phase_in,
    input  logic             phase_valid,
    output logic             phase_ready,
    input  logic             err_clr,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);
    localparam int WB = $clog2(WINDOW);
    localparam int EW = $clog2(ERR_THRESH + 1);

    typedef enum logic {SEED, CHECK} chk_state_t;

    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_head;
    logic       push;
    logic       load;

    logic [3:0] shreg;
    logic [1:0] bit_idx;

    chk_state_t      state;
    chk_state_t      state_nxt;
    logic [6:0]      lfsr;
    logic [2:0]      seed_cnt;
    logic [WB-1:0]   win_bits;
    logic [EW-1:0]   win_errs;
    logic [EW-1:0]   win_errs_inc;
    logic            exp_bit;
    logic            mismatch;
    logic            thresh_hit;

    assign phase_ready = !fifo_full;
    assign push        = phase_valid && !fifo_full;
    // Reload on the last bit as well as when idle, so symbols stream without a bubble.
    assign load        = !fifo_empty && (!serial_valid || bit_idx == 2'd3);

    sym_fifo #(.W(4), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (phase_in),
        .pop      (load),
        .pop_dat  (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg        <= '0;
            bit_idx      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
        end else if (load) begin
            shreg        <= fifo_head;
            bit_idx      <= '0;
            serial_out   <= fifo_head[3];
            serial_valid <= 1'b1;
        end else if (serial_valid && bit_idx != 2'd3) begin
            shreg      <= {shreg[2:0], 1'b0};
            bit_idx    <= bit_idx + 2'd1;
            serial_out <= shreg[2];
        end else begin
            serial_valid <= 1'b0;
        end
    end

    always_comb begin
        exp_bit      = lfsr[6] ^ lfsr[5];
        mismatch     = serial_valid && (state == CHECK) && (serial_out != exp_bit);
        win_errs_inc = win_errs + EW'(mismatch);
        thresh_hit   = mismatch && (win_errs_inc == EW'(ERR_THRESH));
        state_nxt    = state;
        case (state)
            SEED:    if (serial_valid && seed_cnt == 3'd6) state_nxt = CHECK;
            CHECK:   if (thresh_hit) state_nxt = SEED;
            default: state_nxt = SEED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= SEED;
        else      state <= state_nxt;
    end

    assign locked = (state == CHECK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr     <= '0;
            seed_cnt <= '0;
            win_bits <= '0;
            win_errs <= '0;
        end else if (serial_valid) begin
            if (state == SEED) begin
                lfsr     <= {lfsr[5:0], serial_out};
                seed_cnt <= (seed_cnt == 3'd6) ? 3'd0 : seed_cnt + 3'd1;
                win_bits <= '0;
                win_errs <= '0;
            end else begin
                // Free-running reference: a corrupted bit must not poison the generator.
                lfsr <= {lfsr[5:0], exp_bit};
                if (thresh_hit) begin
                    seed_cnt <= '0;
                    win_bits <= '0;
                    win_errs <= '0;
                end else if (win_bits == WB'(WINDOW - 1)) begin
                    win_bits <= '0;
                    win_errs <= '0;
                end else begin
                    win_bits <= win_bits + WB'(1);
                    win_errs <= win_errs_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (mismatch && err_count != {CNT_W{1'b1}}) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_qpsk_phase_receiver.sv
// Bench for qpsk_phase_receiver: queue-based reference of buffer, bit stream and PRBS7 lock checker.
module tb_qpsk_phase_receiver;
    localparam int FIFO_DEPTH = 4;
    localparam int WINDOW     = 64;
    localparam int ERR_THRESH = 8;
    localparam int CNT_W      = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       phase_in;
    logic             phase_valid;
    logic             phase_ready;
    logic             err_clr;
    logic             serial_out;
    logic             serial_valid;
    logic             locked;
    logic [CNT_W-1:0] err_count;

    qpsk_phase_receiver #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WINDOW     (WINDOW),
        .ERR_THRESH (ERR_THRESH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .phase_in     (phase_in),
        .phase_valid  (phase_valid),
        .phase_ready  (phase_ready),
        .err_clr      (err_clr),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .locked       (locked),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: accepted symbols, bits still owed from the current one, lock model.
    logic [3:0] m_q[$];
    logic [3:0] m_cur;
    int         m_rem;
    bit         m_sv;
    bit         m_so;
    bit         m_locked;
    int         m_seed_n;
    bit         m_ref[$];
    int         m_win_bits;
    int         m_win_errs;
    int         m_errs;
    bit         got_bits[$];
    bit         last_acc;
    logic [6:0] gen;

    int stream_lock_at;
    int stream_unlocked;
    int stream_drops;

    task automatic model_reset();
        m_q.delete();
        m_cur = '0; m_rem = 0; m_sv = 0; m_so = 0;
        m_locked = 0; m_seed_n = 0; m_ref.delete();
        m_win_bits = 0; m_win_errs = 0; m_errs = 0;
        got_bits.delete();
    endtask

    task automatic model_checker(input bit clr);
        bit e;
        if (clr) m_errs = 0;
        if (m_sv) begin
            if (!m_locked) begin
                m_ref.push_back(m_so);
                if (m_ref.size() > 7) void'(m_ref.pop_front());
                m_seed_n++;
                if (m_seed_n == 7) begin
                    m_locked = 1; m_seed_n = 0; m_win_bits = 0; m_win_errs = 0;
                end
            end else begin
                e = m_ref[0] ^ m_ref[1];
                m_ref.push_back(e);
                void'(m_ref.pop_front());
                if (m_so != e) begin
                    m_win_errs++;
                    if (!clr && m_errs < (2**CNT_W) - 1) m_errs++;
                end
                if (m_win_errs >= ERR_THRESH) begin
                    m_locked = 0; m_seed_n = 0;
                end else if (m_win_bits == WINDOW - 1) begin
                    m_win_bits = 0; m_win_errs = 0;
                end else begin
                    m_win_bits++;
                end
            end
        end
    endtask

    task automatic model_serializer();
        if (m_q.size() > 0 && m_rem == 0) begin
            m_cur = m_q.pop_front();
            m_so = m_cur[3]; m_sv = 1; m_rem = 3;
        end else if (m_rem > 0) begin
            m_so = m_cur[m_rem-1]; m_rem--;
        end else begin
            m_sv = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [3:0] d, input bit clr);
        bit exp_rdy;
        bit acc;
        phase_valid = v; phase_in = d; err_clr = clr;
        exp_rdy = (m_q.size() < FIFO_DEPTH);
        n_checks++;
        if (phase_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL phase_ready: got %b expected %b at %0t", phase_ready, exp_rdy, $time);
        end
        acc = v && exp_rdy;
        @(posedge clk);
        model_checker(clr);
        model_serializer();
        if (acc) m_q.push_back(d);
        last_acc = acc;
        @(negedge clk);
        phase_valid = 1'b0; err_clr = 1'b0;
        n_checks++;
        if (serial_valid !== m_sv) begin
            n_fail++;
            $display("FAIL serial_valid: got %b expected %b at %0t", serial_valid, m_sv, $time);
        end
        n_checks++;
        if (serial_out !== m_so) begin
            n_fail++;
            $display("FAIL serial_out: got %b expected %b at %0t", serial_out, m_so, $time);
        end
        n_checks++;
        if (locked !== m_locked) begin
            n_fail++;
            $display("FAIL locked: got %b expected %b at %0t", locked, m_locked, $time);
        end
        n_checks++;
        if (err_count !== CNT_W'(m_errs)) begin
            n_fail++;
            $display("FAIL err_count: got %0d expected %0d at %0t", err_count, m_errs, $time);
        end
        if (serial_valid === 1'b1) got_bits.push_back(serial_out);
    endtask

    task automatic next_sym(output logic [3:0] s);
        bit b;
        for (int i = 3; i >= 0; i--) begin
            b = gen[6] ^ gen[5];
            gen = {gen[5:0], b};
            s[i] = b;
        end
    endtask

    // Offers PRBS symbols, holding each until accepted so the bit stream stays contiguous.
    task automatic run_stream(input int nsym, input int flip_from, input int flip_cnt,
                              input logic [3:0] flip_mask, input bit gaps);
        logic [3:0] sym;
        logic [3:0] tx;
        int  k = 0;
        int  budget = 0;
        int  nbits = 0;
        bit  started = 0;
        bit  v;
        stream_lock_at = -1; stream_unlocked = 0; stream_drops = 0;
        next_sym(sym);
        while (k < nsym && budget < nsym * 8 + 50) begin
            v  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            tx = (k >= flip_from && k < flip_from + flip_cnt) ? (sym ^ flip_mask) : sym;
            cycle(v, tx, 1'b0);
            if (stream_lock_at < 0 && locked === 1'b1) stream_lock_at = nbits;
            if (locked === 1'b0) stream_unlocked++;
            if (started && serial_valid !== 1'b1) stream_drops++;
            if (serial_valid === 1'b1) begin started = 1; nbits++; end
            if (last_acc) begin
                k++;
                if (k < nsym) next_sym(sym);
            end
            budget++;
        end
        n_checks++;
        if (k != nsym) begin
            n_fail++;
            $display("FAIL stream_budget: accepted %0d expected %0d", k, nsym);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((m_q.size() > 0 || m_sv) && n < 64) begin
            cycle(1'b0, 4'h0, 1'b0);
            n++;
        end
        n_checks++;
        if (m_q.size() > 0 || m_sv) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d symbols still queued", m_q.size());
        end
    endtask

    task automatic do_reset();
        phase_valid = 1'b0; err_clr = 1'b0; phase_in = 4'h0;
        rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (phase_ready !== 1'b1 || serial_valid !== 1'b0 || serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_io: ready=%b valid=%b out=%b expected 1 0 0",
                     phase_ready, serial_valid, serial_out);
        end
        n_checks++;
        if (locked !== 1'b0 || err_count !== '0) begin
            n_fail++;
            $display("FAIL reset_chk: locked=%b err_count=%0d expected 0 0", locked, err_count);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_single();
        logic [3:0] pat = 4'b1010;
        cycle(1'b1, pat, 1'b0);
        n_checks++;
        if (serial_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: serial_valid got %b expected 0", serial_valid);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 4'h0, 1'b0);
            n_checks++;
            if (serial_valid !== 1'b1 || serial_out !== pat[3-i]) begin
                n_fail++;
                $display("FAIL single_bit%0d: got v=%b d=%b expected v=1 d=%b",
                         i, serial_valid, serial_out, pat[3-i]);
            end
        end
        cycle(1'b0, 4'h0, 1'b0);
        n_checks++;
        if (serial_valid !== 1'b0 || serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_end: got v=%b d=%b expected v=0 d=0", serial_valid, serial_out);
        end
    endtask

    task automatic test_prbs_stream();
        do_reset();
        gen = 7'h7F;
        run_stream(250, 0, 0, 4'h0, 1'b0);
        n_checks++;
        if (stream_lock_at != 7) begin
            n_fail++;
            $display("FAIL prbs_lock_point: locked after %0d bits expected 7", stream_lock_at);
        end
        n_checks++;
        if (stream_drops != 0) begin
            n_fail++;
            $display("FAIL prbs_gaps: %0d idle cycles expected 0", stream_drops);
        end
        drain();
        n_checks++;
        if (err_count !== 16'd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL prbs_clean: err_count=%0d locked=%b expected 0 1", err_count, locked);
        end
    endtask

    task automatic test_single_error();
        run_stream(40, 10, 1, 4'b0100, 1'b0);
        drain();
        n_checks++;
        if (err_count !== 16'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL one_error: err_count=%0d locked=%b expected 1 1", err_count, locked);
        end
        cycle(1'b0, 4'h0, 1'b1);
        n_checks++;
        if (err_count !== 16'd0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clr: err_count=%0d locked=%b expected 0 1", err_count, locked);
        end
    endtask

    task automatic test_resync();
        run_stream(40, 5, 2, 4'hF, 1'b0);
        n_checks++;
        if (stream_unlocked != 7) begin
            n_fail++;
            $display("FAIL resync_unlocked: %0d cycles unlocked expected 7", stream_unlocked);
        end
        drain();
        n_checks++;
        if (err_count !== 16'd8 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL resync_end: err_count=%0d locked=%b expected 8 1", err_count, locked);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] syms[6];
        bit         rdy[6];
        int         bad = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            syms[i] = 4'($urandom);
            rdy[i]  = phase_ready;
            cycle(1'b1, syms[i], 1'b0);
        end
        n_checks++;
        if (rdy[4] !== 1'b1 || rdy[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready: 5th=%b 6th=%b expected 1 0", rdy[4], rdy[5]);
        end
        drain();
        n_checks++;
        if (got_bits.size() != 20) begin
            n_fail++;
            $display("FAIL bp_count: %0d bits expected 20", got_bits.size());
        end else begin
            for (int i = 0; i < 20; i++)
                if (got_bits[i] != syms[i/4][3 - (i % 4)]) bad++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL bp_order: %0d wrong bits expected 0", bad);
            end
        end
    endtask

    task automatic test_reset_midsymbol();
        int seen = 0;
        do_reset();
        cycle(1'b1, 4'($urandom), 1'b0);
        cycle(1'b1, 4'($urandom), 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 4'h0, 1'b0);
            if (serial_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL post_reset_quiet: %0d valid bits expected 0", seen);
        end
        cycle(1'b1, 4'($urandom), 1'b0);
        drain();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 2) != 0, 4'($urandom), $urandom_range(0, 40) == 0);
        drain();
    endtask

    task automatic test_random_prbs();
        logic [3:0] mask;
        do_reset();
        gen  = 7'($urandom_range(1, 127));
        mask = 4'(1 << $urandom_range(0, 3));
        run_stream(120, $urandom_range(10, 100), 1, mask, 1'b1);
        drain();
        n_checks++;
        if (err_count !== 16'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_prbs: err_count=%0d locked=%b expected 1 1", err_count, locked);
        end
    endtask

    initial begin
        rst = 1'b0; phase_valid = 1'b0; phase_in = 4'h0; err_clr = 1'b0;
        test_reset();
        test_single();
        test_prbs_stream();
        test_single_error();
        test_resync();
        test_back_to_back();
        test_reset_midsymbol();
        test_random();
        test_random_prbs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
